// File: rtl/board_rx_ctrl.sv
// Receive sequencer for one serial game-board frame: grants the link,
// strobes the bit-capture datapath, holds the finished board until it is
// acknowledged, and flags aborts (request dropped or sender stalled).
module board_rx_ctrl #(
  parameter int unsigned BOARD_BITS = 256,
  parameter int unsigned IDX_W      = 8,
  parameter int unsigned TIMEOUT    = 16,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tx_req,
  input  logic             tx_valid,
  output logic             tx_grant,
  output logic             cap_en,
  output logic [IDX_W-1:0] cap_idx,
  output logic             board_valid,
  input  logic             board_ack,
  output logic             err,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             busy
);

  localparam int unsigned      ST_W      = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BOARD_BITS - 1);
  localparam logic [ST_W-1:0]  STALL_MAX = ST_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [ST_W-1:0]  stall_q, stall_d;
  logic [ST_W-1:0]  stall_inc;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             err_q, err_d;
  logic             grant_q, valid_q, busy_q;
  logic             cap_en_c;

  // Capture strobe is combinational so the datapath writes the bit in the same cycle it is driven.
  assign cap_en_c  = (state_q == RECV) & tx_req & tx_valid;
  assign stall_inc = stall_q + ST_W'(1);

  // Next-state, bit/stall counters, completion count and abort detection.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    stall_d     = stall_q;
    frame_cnt_d = frame_cnt_q;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        stall_d   = '0;
        if (tx_req) begin
          state_d = RECV;
        end
      end
      RECV: begin
        if (!tx_req) begin
          // Sender released the link mid-frame; partial bits are left in place.
          state_d   = IDLE;
          err_d     = 1'b1;
          bit_cnt_d = '0;
          stall_d   = '0;
        end else if (tx_valid) begin
          stall_d = '0;
          if (bit_cnt_q == LAST_IDX) begin
            state_d     = DONE;
            bit_cnt_d   = '0;
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
          end else begin
            bit_cnt_d = bit_cnt_q + IDX_W'(1);
          end
        end else begin
          stall_d = stall_inc;
          if (stall_inc == STALL_MAX) begin
            state_d   = IDLE;
            err_d     = 1'b1;
            bit_cnt_d = '0;
            stall_d   = '0;
          end
        end
      end
      DONE: begin
        if (board_ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
        stall_d   = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      stall_q     <= '0;
      frame_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      stall_q     <= stall_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
    end
  end

  // Registered state decodes, loaded from the next state so they align with state_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      grant_q <= (state_d == RECV);
      valid_q <= (state_d == DONE);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign tx_grant    = grant_q;
  assign cap_en      = cap_en_c;
  assign cap_idx     = bit_cnt_q;
  assign board_valid = valid_q;
  assign err         = err_q;
  assign frame_cnt   = frame_cnt_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_board_rx_ctrl.sv
// Bench for board_rx_ctrl: a frame-level driver pushes expected captures and
// frame outcomes into queues; a negedge monitor pops and compares them.
module tb_board_rx_ctrl;

  localparam int unsigned BOARD_BITS = 256;
  localparam int unsigned IDX_W      = 8;
  localparam int unsigned TIMEOUT    = 16;
  localparam int unsigned CNT_W      = 4;
  localparam int          EV_ERR     = -1;

  logic             clk = 1'b0;
  logic             reset;
  logic             tx_req, tx_valid, board_ack;
  logic             tx_grant, cap_en, board_valid, err, busy;
  logic [IDX_W-1:0] cap_idx;
  logic [CNT_W-1:0] frame_cnt;

  int total = 0;
  int bad   = 0;
  int cap_q[$];
  int evt_q[$];
  int exp_cnt = 0;
  int gap[BOARD_BITS];
  logic bv_prev = 1'b0;

  board_rx_ctrl #(
    .BOARD_BITS(BOARD_BITS), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .tx_req(tx_req), .tx_valid(tx_valid),
    .tx_grant(tx_grant), .cap_en(cap_en), .cap_idx(cap_idx),
    .board_valid(board_valid), .board_ack(board_ack), .err(err),
    .frame_cnt(frame_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every strobe, error pulse and board completion must match the queues.
  always @(negedge clk) begin
    int e;
    if (reset) begin
      bv_prev = 1'b0;
    end else begin
      if (cap_en) begin
        if (cap_q.size() == 0) begin
          chk("unexpected_cap_en", 1, 0);
        end else begin
          e = cap_q.pop_front();
          chk("cap_idx", int'(cap_idx), e);
          chk("cap_en_without_grant", int'(tx_grant), 1);
        end
      end
      if (err) begin
        if (evt_q.size() == 0) begin
          chk("unexpected_err", 1, 0);
        end else begin
          e = evt_q.pop_front();
          chk("err_event", EV_ERR, e);
          chk("err_grant", int'(tx_grant), 0);
          chk("err_busy", int'(busy), 0);
        end
      end
      if (board_valid && !bv_prev) begin
        if (evt_q.size() == 0) begin
          chk("unexpected_board_valid", 1, 0);
        end else begin
          e = evt_q.pop_front();
          chk("done_frame_cnt", int'(frame_cnt), e);
        end
      end
      bv_prev = board_valid;
    end
  end

  task automatic fill_gaps(input int one_in);
    for (int b = 0; b < int'(BOARD_BITS); b++)
      gap[b] = (one_in > 0 && ($urandom % one_in) == 0) ?
               int'($urandom_range(1, TIMEOUT - 1)) : 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant();
    int i;
    for (i = 0; i < 8; i++) begin
      if (tx_grant) break;
      tick();
    end
    if (!tx_grant) chk("grant_timeout", 0, 1);
  endtask

  // mode 0: complete, 1: stall abort, 2: request drop, 3: reset; stop applies to 1..3.
  task automatic run_frame(input int mode, input int stop, input int hold, input bit b2b);
    tx_req   = 1'b1;
    tx_valid = 1'b0;
    wait_grant();
    for (int b = 0; b < int'(BOARD_BITS); b++) begin
      if (mode != 0 && b == stop) break;
      for (int g = 0; g < gap[b]; g++) begin
        tx_valid  = 1'b0;
        board_ack = 1'($urandom % 2);
        tick();
      end
      board_ack = 1'b0;
      cap_q.push_back(b);
      if (b == int'(BOARD_BITS) - 1) begin
        exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
        evt_q.push_back(exp_cnt);
      end
      tx_valid = 1'b1;
      tick();
    end
    tx_valid = 1'b0;
    case (mode)
      1: begin
        evt_q.push_back(EV_ERR);
        repeat (TIMEOUT) tick();
        tx_req = 1'b0;
        chk("stall_grant_dropped", int'(tx_grant), 0);
        chk("stall_cnt_kept", int'(frame_cnt), exp_cnt);
        tick();
      end
      2: begin
        evt_q.push_back(EV_ERR);
        tx_req   = 1'b0;
        tx_valid = 1'($urandom % 2);
        tick();
        tx_valid = 1'b0;
        chk("reqdrop_valid", int'(board_valid), 0);
        tick();
      end
      3: begin
        reset = 1'b1;
        #1;
        chk("rst_mid_out", int'({tx_grant, cap_en, cap_idx, board_valid, err, busy}), 0);
        chk("rst_mid_cnt", int'(frame_cnt), 0);
        exp_cnt = 0;
        tx_req  = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk("rst_no_err", int'(err), 0);
      end
      default: begin
        chk("done_valid", int'(board_valid), 1);
        chk("done_busy", int'(busy), 1);
        for (int h = 0; h < hold; h++) begin
          tx_req   = b2b ? 1'b1 : 1'($urandom % 2);
          tx_valid = 1'($urandom % 2);
          tick();
          chk("hold_grant", int'(tx_grant), 0);
          chk("hold_valid", int'(board_valid), 1);
        end
        tx_req    = b2b;
        tx_valid  = 1'b0;
        board_ack = 1'b1;
        tick();
        board_ack = 1'b0;
        chk("ack_valid_drop", int'(board_valid), 0);
        chk("ack_idle_grant", int'(tx_grant), 0);
        chk("ack_idle_busy", int'(busy), 0);
        if (b2b) begin
          tick();
          chk("b2b_grant", int'(tx_grant), 1);
        end
      end
    endcase
  endtask

  initial begin
    int mode;
    reset     = 1'b1;
    tx_req    = 1'b0;
    tx_valid  = 1'b0;
    board_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", int'({tx_grant, cap_en, cap_idx, board_valid, err, busy}), 0);
    chk("reset_cnt", int'(frame_cnt), 0);
    reset = 1'b0;
    tick();

    fill_gaps(0);
    run_frame(0, 0, 2, 1'b0);
    chk("nominal_cnt", int'(frame_cnt), 1);

    fill_gaps(0);
    gap[100] = 3;
    run_frame(0, 0, 0, 1'b0);

    fill_gaps(0);
    run_frame(1, 40, 0, 1'b0);
    run_frame(2, 200, 0, 1'b0);
    run_frame(3, 10, 0, 1'b0);

    run_frame(0, 0, 20, 1'b1);
    run_frame(0, 0, 1, 1'b0);
    chk("b2b_cnt", int'(frame_cnt), 2);

    for (int f = 0; f < 12; f++) begin
      fill_gaps(40);
      mode = int'($urandom % 3);
      run_frame(mode, int'($urandom_range(0, BOARD_BITS - 1)),
                int'($urandom_range(0, 4)), 1'($urandom % 2));
    end
    tx_req = 1'b0;
    tick();

    reset = 1'b1;
    exp_cnt = 0;
    tick();
    reset = 1'b0;
    tick();
    for (int f = 0; f < (1 << CNT_W) + 1; f++) begin
      fill_gaps(60);
      run_frame(0, 0, int'($urandom_range(0, 2)), 1'($urandom % 2));
    end
    tx_req = 1'b0;
    tick();
    tick();
    chk("wrap_cnt", int'(frame_cnt), exp_cnt);
    chk("wrap_cnt_is_one", exp_cnt, 1);
    chk("cap_queue_drained", cap_q.size(), 0);
    chk("evt_queue_drained", evt_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running want done");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule
